// File: rtl/mul_div_sequencer_if.sv
// Handshake and operand bus between the execute stage and the RV32M
// multiply/divide sequencer.
interface mul_div_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [2:0]            op;
    logic [DATA_WIDTH-1:0] rs1;
    logic [DATA_WIDTH-1:0] rs2;
    logic                  clear;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;

    // Execute stage side.
    modport master (
        output start, op, rs1, rs2, clear,
        input  busy, done, result
    );

    // Sequencer side.
    modport slave (
        input  start, op, rs1, rs2, clear,
        output busy, done, result
    );
endinterface

// File: rtl/mul_div_sequencer.sv
// RV32M multiply/divide sequencer: fixed-latency multiply, 32-step restoring
// divide, divide-by-zero and signed-overflow short cuts, flush via clear.
module mul_div_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int MUL_LATENCY = 2
) (
    input logic                clk,
    input logic                rst,
    mul_div_sequencer_if.slave bus
);
    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t         state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [2:0]     op_q, op_d;
    logic [W-1:0]   rs1_q, rs1_d;
    logic [W-1:0]   rs2_q, rs2_d;
    logic [W-1:0]   quo_q, quo_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [W-1:0]   result_q, result_d;

    // Operand interpretation of the latched instruction.
    logic           div_signed, quo_neg, rem_neg;
    logic [W-1:0]   dvs_mag;
    assign div_signed = ~op_q[0];
    assign quo_neg    = div_signed & (rs1_q[W-1] ^ rs2_q[W-1]);
    assign rem_neg    = div_signed & rs1_q[W-1];
    assign dvs_mag    = (div_signed & rs2_q[W-1]) ? (0 - rs2_q) : rs2_q;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits.
    logic [W:0]     rem_shift;
    logic [W+1:0]   rem_diff;
    logic [W-1:0]   quo_step, rem_step;
    assign rem_shift = {rem_q, quo_q[W-1]};
    assign rem_diff  = {1'b0, rem_shift} - {2'b00, dvs_mag};
    assign quo_step  = {quo_q[W-2:0], ~rem_diff[W+1]};
    assign rem_step  = rem_diff[W+1] ? rem_shift[W-1:0] : rem_diff[W-1:0];

    // Multiply: MULH/MULHSU treat rs1 as signed, MULH alone treats rs2 as
    // signed; MUL only uses the low half so its extension is irrelevant.
    logic                  a_sgn, b_sgn;
    logic signed [W:0]     a_ext, b_ext;
    logic signed [2*W+1:0] prod;
    assign a_sgn = (op_q[1:0] != 2'b11);
    assign b_sgn = ~op_q[1];
    assign a_ext = $signed({a_sgn & rs1_q[W-1], rs1_q});
    assign b_ext = $signed({b_sgn & rs2_q[W-1], rs2_q});
    assign prod  = $signed({{(W+1){a_ext[W]}}, a_ext}) * $signed({{(W+1){b_ext[W]}}, b_ext});

    logic accept, in_is_signed, overflow;
    assign accept       = (state_q == IDLE) & bus.start & ~bus.clear;
    assign in_is_signed = ~bus.op[0];
    assign overflow     = in_is_signed & (bus.rs1 == {1'b1, {(W-1){1'b0}}}) & (&bus.rs2);

    // Next-state, datapath and result selection.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d  = bus.op;
                    rs1_d = bus.rs1;
                    rs2_d = bus.rs2;
                    cnt_d = '0;
                    quo_d = (in_is_signed & bus.rs1[W-1]) ? (0 - bus.rs1) : bus.rs1;
                    rem_d = '0;
                    if (!bus.op[2]) begin
                        state_d = MUL;
                    end else if (bus.rs2 == '0) begin
                        state_d  = DONE;
                        result_d = bus.op[1] ? bus.rs1 : '1;
                    end else if (overflow) begin
                        state_d  = DONE;
                        result_d = bus.op[1] ? '0 : {1'b1, {(W-1){1'b0}}};
                    end else begin
                        state_d = DIV;
                    end
                end
            end
            MUL: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(MUL_LATENCY - 1)) begin
                    state_d  = DONE;
                    result_d = (op_q[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
                end
            end
            DIV: begin
                cnt_d = cnt_q + 5'd1;
                quo_d = quo_step;
                rem_d = rem_step;
                if (cnt_q == 5'(W - 1)) begin
                    state_d  = DONE;
                    if (op_q[1]) result_d = rem_neg ? (0 - rem_step) : rem_step;
                    else         result_d = quo_neg ? (0 - quo_step) : quo_step;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (bus.clear) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    // State, counter, operand and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: only control state and the visible result are reset; the
            // operand and divider registers are always loaded before use.
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
        op_q  <= op_d;
        rs1_q <= rs1_d;
        rs2_q <= rs2_d;
        quo_q <= quo_d;
        rem_q <= rem_d;
    end

    assign bus.busy   = bus.clear ? 1'b0
                      : (((state_q == IDLE) & bus.start) | (state_q == MUL) | (state_q == DIV));
    assign bus.done   = (state_q == DONE) & ~bus.clear;
    assign bus.result = result_q;
endmodule
